// File: rtl/qspi_phy_sync.sv
// rtl/qspi_phy_sync.sv - QSPI target pin shifter: input synchronisers, phase deserialiser, read-data serialiser
// Mode 0 only: the target samples IO on SCK rise and drives IO on SCK fall.
module qspi_phy_sync #(
  parameter int IOREG_BITS       = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        spi_sck_i,
  input  logic                        spi_cs_n_i,
  input  logic [3:0]                  spi_io_i,
  output logic [3:0]                  spi_io_o,
  output logic [3:0]                  spi_io_oe_o,
  input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
  input  logic [1:0]                  txnmode_i,
  input  logic                        txndir_i,
  input  logic [IOREG_BITS-1:0]       txndata_i,
  output logic [IOREG_BITS-1:0]       txndata_o,
  output logic                        txndone_o,
  output logic                        txnreset_o
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [3:0]             io_sync [SYNC_STAGES];
  logic                   sck_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sck_sync <= '1;
      cs_sync  <= '1;
      sck_d    <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) io_sync[i] <= '0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      sck_d      <= sck_sync[SYNC_STAGES-1];
      io_sync[0] <= spi_io_i;
      for (int i = 1; i < SYNC_STAGES; i++) io_sync[i] <= io_sync[i-1];
    end
  end

  logic       sck_s;
  logic       cs_s;
  logic [3:0] io_s;
  logic       sck_rise;
  logic       sck_fall;

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign io_s       = io_sync[SYNC_STAGES-1];
  assign sck_rise   = ~cs_s & sck_s & ~sck_d;
  assign sck_fall   = ~cs_s & ~sck_s & sck_d;
  assign txnreset_o = cs_s;

  // cfg_valid marks that the current phase has seen its first edge and its config is latched.
  logic                        cfg_valid;
  logic [CYCLE_COUNT_BITS-1:0] bc_q;
  logic [1:0]                  mode_q;
  logic                        dir_q;
  logic [CYCLE_COUNT_BITS-1:0] eff_bc;
  logic [1:0]                  eff_mode;
  logic                        eff_dir;

  assign eff_bc   = cfg_valid ? bc_q   : txnbc_i;
  assign eff_mode = cfg_valid ? mode_q : txnmode_i;
  assign eff_dir  = cfg_valid ? dir_q  : txndir_i;

  logic [CYCLE_COUNT_BITS:0]   lanes;
  logic [3:0]                  in_mask;
  logic [3:0]                  oe_mask;

  always_comb begin
    lanes   = (CYCLE_COUNT_BITS+1)'(4);
    in_mask = 4'b1111;
    oe_mask = 4'b1111;
    case (eff_mode)
      2'b00: begin
        lanes   = (CYCLE_COUNT_BITS+1)'(1);
        in_mask = 4'b0001;
        oe_mask = 4'b0010;
      end
      2'b01: begin
        lanes   = (CYCLE_COUNT_BITS+1)'(2);
        in_mask = 4'b0011;
        oe_mask = 4'b0011;
      end
      default: ;
    endcase
  end

  logic [CYCLE_COUNT_BITS-1:0] bitcnt;
  logic [IOREG_BITS-1:0]       shift_in;
  logic [IOREG_BITS-1:0]       shift_out;
  logic [CYCLE_COUNT_BITS:0]   cnt_next;
  logic                        complete;
  logic [IOREG_BITS-1:0]       rx_next;

  assign cnt_next = {1'b0, bitcnt} + lanes;
  assign complete = cnt_next >= {1'b0, eff_bc};
  assign rx_next  = (shift_in << lanes) | IOREG_BITS'(io_s & in_mask);

  // Left-align the low txnbc bits of the read word so the MSB leaves first.
  logic [31:0]           bc_w;
  logic [IOREG_BITS-1:0] tx_aligned;
  logic [IOREG_BITS-1:0] tx_src;
  logic [3:0]            tx_pins;

  always_comb begin
    bc_w = 32'(eff_bc);
    if (bc_w == 32'd0)
      tx_aligned = '0;
    else if (bc_w >= 32'(IOREG_BITS))
      tx_aligned = txndata_i;
    else
      tx_aligned = txndata_i << (32'(IOREG_BITS) - bc_w);
  end

  assign tx_src = cfg_valid ? shift_out : tx_aligned;

  always_comb begin
    tx_pins = tx_src[IOREG_BITS-1:IOREG_BITS-4];
    case (eff_mode)
      2'b00:   tx_pins = {2'b00, tx_src[IOREG_BITS-1], 1'b0};
      2'b01:   tx_pins = {2'b00, tx_src[IOREG_BITS-1:IOREG_BITS-2]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cfg_valid   <= 1'b0;
      bc_q        <= '0;
      mode_q      <= '0;
      dir_q       <= 1'b0;
      bitcnt      <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      spi_io_o    <= '0;
      spi_io_oe_o <= '0;
      txndata_o   <= '0;
      txndone_o   <= 1'b0;
    end else begin
      txndone_o <= 1'b0;
      if (cs_s) begin
        cfg_valid   <= 1'b0;
        bitcnt      <= '0;
        shift_in    <= '0;
        shift_out   <= '0;
        spi_io_o    <= '0;
        spi_io_oe_o <= '0;
      end else begin
        if ((sck_rise || sck_fall) && !cfg_valid) begin
          cfg_valid <= 1'b1;
          bc_q      <= txnbc_i;
          mode_q    <= txnmode_i;
          dir_q     <= txndir_i;
        end
        if (sck_rise) begin
          if (complete) begin
            txndone_o <= 1'b1;
            txndata_o <= rx_next;
            bitcnt    <= '0;
            shift_in  <= '0;
            cfg_valid <= 1'b0;
          end else begin
            bitcnt   <= cnt_next[CYCLE_COUNT_BITS-1:0];
            shift_in <= rx_next;
          end
        end
        // A fall in an output phase drives the next lanes; a fall in an input phase releases the bus.
        if (sck_fall) begin
          if (eff_dir) begin
            spi_io_o    <= tx_pins;
            spi_io_oe_o <= oe_mask;
            shift_out   <= tx_src << lanes;
          end else begin
            spi_io_o    <= '0;
            spi_io_oe_o <= '0;
            shift_out   <= '0;
          end
        end
      end
    end
  end

endmodule
